// File: rtl/conv3x3_stream_if.sv
// Pixel-stream bundle for the 3x3 gradient engine: raster input with frame
// marker on one side, filtered output on the other.
interface conv3x3_stream_if #(
    parameter int unsigned XWIDTH = 12,
    parameter int unsigned YWIDTH = 12
);
    logic              iSOF;
    logic              iDVAL;
    logic [XWIDTH-1:0] iPIX;
    logic              oDVAL;
    logic [YWIDTH-1:0] oY;

    modport master (
        output iSOF,
        output iDVAL,
        output iPIX,
        input  oDVAL,
        input  oY
    );

    modport slave (
        input  iSOF,
        input  iDVAL,
        input  iPIX,
        output oDVAL,
        output oY
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel gradient engine with internal line buffers, border
// masking, selectable kernel, saturation and optional binarisation.
module conv3x3_stream #(
    parameter int unsigned XWIDTH = 12,
    parameter int unsigned YWIDTH = 12,
    parameter int unsigned LINE_W = 640,
    parameter int unsigned CW     = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    conv3x3_stream_if.slave   bus,
    input  logic [1:0]        iMODE,
    input  logic              iBIN,
    input  logic [YWIDTH-1:0] iTHRESH
);
    localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned GW = XWIDTH + 2;
    localparam int unsigned SW = XWIDTH + 3;
    localparam int unsigned MW = (SW > YWIDTH) ? SW : YWIDTH;

    logic [XWIDTH-1:0] lineBuf0 [LINE_W];
    logic [XWIDTH-1:0] lineBuf1 [LINE_W];

    logic [CW-1:0]     col;
    logic [1:0]        row;
    logic [CW-1:0]     colEff;
    logic [1:0]        rowEff;
    logic [AW-1:0]     addr;
    logic [XWIDTH-1:0] rd0;
    logic [XWIDTH-1:0] rd1;

    logic [XWIDTH-1:0] win [3][3];
    logic              vA;
    logic              borderA;

    logic              vB;
    logic              borderB;
    logic [GW-1:0]     regL;
    logic [GW-1:0]     regR;
    logic [GW-1:0]     regT;
    logic [GW-1:0]     regB;

    logic [GW-1:0]     gx;
    logic [GW-1:0]     gy;
    logic [SW-1:0]     sumG;
    logic [MW-1:0]     selV;
    logic [YWIDTH-1:0] satV;
    logic [YWIDTH-1:0] yNext;

    // A frame marker overrides the counters for the pixel it qualifies
    always_comb begin
        colEff = bus.iSOF ? '0 : col;
        rowEff = bus.iSOF ? '0 : row;
        addr   = AW'(colEff);
        rd0    = lineBuf0[addr];
        rd1    = lineBuf1[addr];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col <= '0;
            row <= '0;
        end else if (bus.iDVAL) begin
            if (colEff == CW'(LINE_W - 1)) begin
                col <= '0;
                row <= (rowEff == 2'd3) ? 2'd3 : rowEff + 2'd1;
            end else begin
                col <= colEff + CW'(1);
                row <= rowEff;
            end
        end
    end

    // Line buffers hold the two previous lines; contents are masked until row 2
    always_ff @(posedge iCLK) begin
        if (bus.iDVAL) begin
            lineBuf1[addr] <= rd0;
            lineBuf0[addr] <= bus.iPIX;
        end
    end

    // Stage A: window shift and border flag from pre-increment position
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            vA      <= 1'b0;
            borderA <= 1'b0;
        end else begin
            vA <= bus.iDVAL;
            if (bus.iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= rd1;
                win[1][2] <= rd0;
                win[2][2] <= bus.iPIX;
                borderA   <= (rowEff >= 2'd2) && (colEff >= CW'(2));
            end else begin
                borderA   <= 1'b0;
            end
        end
    end

    // Stage B: weighted column and row sums, full width
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            vB      <= 1'b0;
            borderB <= 1'b0;
            regL    <= '0;
            regR    <= '0;
            regT    <= '0;
            regB    <= '0;
        end else begin
            vB      <= vA;
            borderB <= borderA;
            regL    <= GW'(win[0][0]) + GW'({win[1][0], 1'b0}) + GW'(win[2][0]);
            regR    <= GW'(win[0][2]) + GW'({win[1][2], 1'b0}) + GW'(win[2][2]);
            regT    <= GW'(win[0][0]) + GW'({win[0][1], 1'b0}) + GW'(win[0][2]);
            regB    <= GW'(win[2][0]) + GW'({win[2][1], 1'b0}) + GW'(win[2][2]);
        end
    end

    // Stage C: magnitude, kernel select, saturation, mask, threshold
    always_comb begin
        gx    = (regL >= regR) ? regL - regR : regR - regL;
        gy    = (regT >= regB) ? regT - regB : regB - regT;
        sumG  = SW'(gx) + SW'(gy);
        selV  = MW'(sumG);
        satV  = '0;
        yNext = '0;
        case (iMODE)
            2'd0:    selV = MW'(gx);
            2'd1:    selV = MW'(gy);
            default: selV = MW'(sumG);
        endcase
        satV = (selV > MW'({YWIDTH{1'b1}})) ? {YWIDTH{1'b1}} : YWIDTH'(selV);
        if (vB && borderB) begin
            if (iBIN) begin
                yNext = (satV >= iTHRESH) ? {YWIDTH{1'b1}} : '0;
            end else begin
                yNext = satV;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            bus.oDVAL <= 1'b0;
            bus.oY    <= '0;
        end else begin
            bus.oDVAL <= vB;
            bus.oY    <= yNext;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised directed bench for conv3x3_stream against an image-based
// Sobel reference model (LINE_W=8, 12-bit in/out).
module tb_conv3x3_stream;
    localparam int LW = 8;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [1:0]  iMODE;
    logic        iBIN;
    logic [11:0] iTHRESH;

    conv3x3_stream_if #(.XWIDTH(12), .YWIDTH(12)) bus ();

    conv3x3_stream #(
        .XWIDTH(12),
        .YWIDTH(12),
        .LINE_W(LW),
        .CW(3)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus(bus),
        .iMODE(iMODE),
        .iBIN(iBIN),
        .iTHRESH(iTHRESH)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int due;
        bit border;
        int gx;
        int gy;
    } exp_t;

    exp_t q[$];
    int   img [8][LW];
    int   cyc    = 0;
    int   checks = 0;
    int   errs   = 0;
    int   hiVal  = 1000;

    function automatic int absDiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Output rule applied with the controls present when the result is produced
    function automatic int finalY(input exp_t e);
        int v;
        if (!e.border) return 0;
        case (iMODE)
            2'd0:    v = e.gx;
            2'd1:    v = e.gy;
            default: v = e.gx + e.gy;
        endcase
        if (v > 4095) v = 4095;
        if (iBIN) v = (v >= int'(iTHRESH)) ? 4095 : 0;
        return v;
    endfunction

    function automatic int pixFor(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : hiVal;
            2:       return (r < 2) ? 0 : 1000;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic step(input bit dv, input bit sf, input int pix, input int r, input int c);
        exp_t e;
        int   expY;
        bus.iDVAL = dv;
        bus.iSOF  = sf;
        bus.iPIX  = 12'(pix);
        @(posedge iCLK);
        cyc++;
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e    = q.pop_front();
            expY = finalY(e);
            checks += 2;
            assert (bus.oDVAL === 1'b1) else begin
                errs++;
                $error("FAIL oDVAL cyc=%0d obs=%0b exp=1", cyc, bus.oDVAL);
            end
            assert (bus.oY === 12'(expY)) else begin
                errs++;
                $error("FAIL oY cyc=%0d obs=%0d exp=%0d", cyc, bus.oY, expY);
            end
        end else begin
            checks++;
            assert (bus.oDVAL === 1'b0) else begin
                errs++;
                $error("FAIL oDVAL_idle cyc=%0d obs=%0b exp=0", cyc, bus.oDVAL);
            end
        end
        if (dv) begin
            img[r][c] = pix;
            e.due    = cyc + 2;
            e.border = (r >= 2) && (c >= 2);
            e.gx     = 0;
            e.gy     = 0;
            if (e.border) begin
                e.gx = absDiff(img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2],
                               img[r-2][c]   + 2*img[r-1][c]   + img[r][c]);
                e.gy = absDiff(img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c],
                               img[r][c-2]   + 2*img[r][c-1]   + img[r][c]);
            end
            q.push_back(e);
        end
    endtask

    // Drives a frame in raster order; gaps carry random iSOF that must be ignored
    task automatic driveFrame(input int rows, input int kind, input int gapPct,
                              input bit useSof, input int stopAfter);
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < LW; c++) begin
                if (stopAfter >= 0 && n == stopAfter) return;
                while (int'($urandom_range(0, 99)) < gapPct)
                    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), 0, 0);
                step(1'b1, useSof && r == 0 && c == 0, pixFor(kind, r, c), r, c);
                n++;
            end
        end
    endtask

    initial begin
        iRST      = 1'b0;
        iMODE     = 2'd2;
        iBIN      = 1'b0;
        iTHRESH   = '0;
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iPIX  = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 0;
        #1;
        checks += 2;
        assert (bus.oDVAL === 1'b0) else begin
            errs++;
            $error("FAIL reset_oDVAL obs=%0b exp=0", bus.oDVAL);
        end
        assert (bus.oY === 12'd0) else begin
            errs++;
            $error("FAIL reset_oY obs=%0d exp=0", bus.oY);
        end
        #11 iRST = 1'b1;

        // Flat frame gives zero gradient everywhere
        iMODE = 2'd2;
        driveFrame(4, 0, 0, 1'b1, -1);

        // Vertical step: Gx peaks at the two straddling columns, Gy is zero
        hiVal = 1000;
        iMODE = 2'd0;
        driveFrame(4, 1, 0, 1'b1, -1);
        iMODE = 2'd1;
        driveFrame(4, 1, 0, 1'b1, -1);

        // Saturation with a full-scale step, then horizontal step in sum mode
        hiVal = 4095;
        iMODE = 2'd2;
        driveFrame(3, 1, 0, 1'b1, -1);
        driveFrame(4, 2, 0, 1'b1, -1);
        iMODE = 2'd3;
        driveFrame(4, 2, 0, 1'b1, -1);

        // Random frames, gapless then with gaps
        iMODE = 2'($urandom_range(0, 3));
        driveFrame(5, 3, 0, 1'b1, -1);
        iMODE = 2'd2;
        driveFrame(5, 3, 30, 1'b1, -1);

        // Binarisation right at and just above the step magnitude
        hiVal   = 1000;
        iMODE   = 2'd0;
        iBIN    = 1'b1;
        iTHRESH = 12'd4000;
        driveFrame(4, 1, 0, 1'b1, -1);
        iTHRESH = 12'd4001;
        driveFrame(4, 1, 0, 1'b1, -1);
        iBIN    = 1'b0;

        // Frame restart in mid-line at col 5
        iMODE = 2'd2;
        driveFrame(4, 3, 0, 1'b1, 3*LW + 5);
        driveFrame(4, 3, 10, 1'b1, -1);

        // Asynchronous reset mid-line, then restart without a frame marker
        driveFrame(4, 3, 0, 1'b1, LW + 5);
        iRST = 1'b0;
        #1;
        checks += 2;
        assert (bus.oDVAL === 1'b0) else begin
            errs++;
            $error("FAIL rst_mid_oDVAL obs=%0b exp=0", bus.oDVAL);
        end
        assert (bus.oY === 12'd0) else begin
            errs++;
            $error("FAIL rst_mid_oY obs=%0d exp=0", bus.oY);
        end
        q.delete();
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 0);
        iRST = 1'b1;
        driveFrame(4, 3, 0, 1'b0, -1);

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
